idex_hazard_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection and bubble insertion for the 16-bit CPU. It sits between decode and execute. It drives the idex_* register fields that the forwarding unit compares against exmem_rd/memwb_rd. It gates PC and IF/ID writes during stalls and honours EX-stage flush and memory-hold requests.

---
 rtl/idex_hazard_stage.sv | 159 +++++++++++++++
 tb/tb_idex_hazard_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Ports: clk/rst_n (sync active-low reset); id_* decoded fields from decode;
//   ex_flush kills the instruction entering EX; mem_hold freezes the stage;
//   pc_write/ifid_write gate upstream writes; idex_* registered ID/EX fields;
//   bubble_count saturating count of inserted load-use bubbles.
module idex_hazard_stage #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic [3:0]       id_rd,
    input  logic             id_uses_rt,
    input  logic [15:0]      id_rs_data,
    input  logic [15:0]      id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             ex_flush,
    input  logic             mem_hold,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_valid,
    output logic [3:0]       idex_rs,
    output logic [3:0]       idex_rt,
    output logic [3:0]       idex_rd,
    output logic [15:0]      idex_rs_data,
    output logic [15:0]      idex_rt_data,
    output logic [15:0]      idex_imm,
    output logic [3:0]       idex_alu_op,
    output logic             idex_alusrc,
    output logic             idex_regwrite,
    output logic             idex_memread,
    output logic             idex_memwrite,
    output logic             idex_memtoreg,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] REM_INIT = 2'(LOAD_USE_BUBBLES - 1);

    state_t     state, state_n;
    logic [1:0] rem, rem_n;
    logic       hz;
    logic       load_id;
    logic       load_bubble;
    logic       count_bubble;

    // Producer in EX is a load whose result the decoding instruction needs.
    assign hz = id_valid & idex_valid & idex_memread & (idex_rd != 4'd0)
              & ((idex_rd == id_rs) | (id_uses_rt & (idex_rd == id_rt)));

    always_comb begin
        state_n      = state;
        rem_n        = rem;
        load_id      = 1'b0;
        load_bubble  = 1'b0;
        count_bubble = 1'b0;
        pc_write     = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b0;
        end else if (mem_hold) begin
            pc_write = 1'b0;
        end else if (ex_flush) begin
            load_bubble = 1'b1;
            state_n     = RUN;
            rem_n       = 2'd0;
            pc_write    = 1'b1;
        end else if (state == STALL) begin
            // Remaining bubbles are inserted without re-checking the hazard.
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
            rem_n        = rem - 2'd1;
            if (rem == 2'd1) begin
                state_n = RUN;
            end
        end else if (hz) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
                state_n = STALL;
                rem_n   = REM_INIT;
            end
        end else begin
            load_id  = 1'b1;
            pc_write = 1'b1;
        end
    end

    assign ifid_write = pc_write;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            rem           <= 2'd0;
            idex_valid    <= 1'b0;
            idex_rs       <= 4'd0;
            idex_rt       <= 4'd0;
            idex_rd       <= 4'd0;
            idex_rs_data  <= 16'd0;
            idex_rt_data  <= 16'd0;
            idex_imm      <= 16'd0;
            idex_alu_op   <= 4'd0;
            idex_alusrc   <= 1'b0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_memtoreg <= 1'b0;
            bubble_count  <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            if (load_bubble || (load_id && !id_valid)) begin
                idex_valid    <= 1'b0;
                idex_rs       <= 4'd0;
                idex_rt       <= 4'd0;
                idex_rd       <= 4'd0;
                idex_rs_data  <= 16'd0;
                idex_rt_data  <= 16'd0;
                idex_imm      <= 16'd0;
                idex_alu_op   <= 4'd0;
                idex_alusrc   <= 1'b0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
                idex_memwrite <= 1'b0;
                idex_memtoreg <= 1'b0;
            end else if (load_id) begin
                idex_valid    <= 1'b1;
                idex_rs       <= id_rs;
                idex_rt       <= id_rt;
                idex_rd       <= id_rd;
                idex_rs_data  <= id_rs_data;
                idex_rt_data  <= id_rt_data;
                idex_imm      <= id_imm;
                idex_alu_op   <= id_alu_op;
                idex_alusrc   <= id_alusrc;
                idex_regwrite <= id_regwrite;
                idex_memread  <= id_memread;
                idex_memwrite <= id_memwrite;
                idex_memtoreg <= id_memtoreg;
            end
            if (count_bubble && (bubble_count != '1)) begin
                bubble_count <= bubble_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Bench for idex_hazard_stage: two instances (1 bubble / CNT_W=4 and
// 3 bubbles / CNT_W=16) checked against a cycle-level reference model.
module tb_idex_hazard_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_rs, id_rt, id_rd, id_alu_op;
    logic        id_uses_rt;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        ex_flush, mem_hold;

    logic        pcw_a, ifw_a, v_a, as_a, rw_a, mr_a, mw_a, mt_a;
    logic [3:0]  rs_a, rt_a, rd_a, op_a;
    logic [15:0] d1_a, d2_a, im_a;
    logic [3:0]  cnt_a;
    logic        pcw_b, ifw_b, v_b, as_b, rw_b, mr_b, mw_b, mt_b;
    logic [3:0]  rs_b, rt_b, rd_b, op_b;
    logic [15:0] d1_b, d2_b, im_b;
    logic [15:0] cnt_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idex_hazard_stage #(.LOAD_USE_BUBBLES(1), .CNT_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .ex_flush(ex_flush), .mem_hold(mem_hold),
        .pc_write(pcw_a), .ifid_write(ifw_a), .idex_valid(v_a),
        .idex_rs(rs_a), .idex_rt(rt_a), .idex_rd(rd_a),
        .idex_rs_data(d1_a), .idex_rt_data(d2_a), .idex_imm(im_a),
        .idex_alu_op(op_a), .idex_alusrc(as_a), .idex_regwrite(rw_a),
        .idex_memread(mr_a), .idex_memwrite(mw_a), .idex_memtoreg(mt_a),
        .bubble_count(cnt_a)
    );

    idex_hazard_stage #(.LOAD_USE_BUBBLES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .ex_flush(ex_flush), .mem_hold(mem_hold),
        .pc_write(pcw_b), .ifid_write(ifw_b), .idex_valid(v_b),
        .idex_rs(rs_b), .idex_rt(rt_b), .idex_rd(rd_b),
        .idex_rs_data(d1_b), .idex_rt_data(d2_b), .idex_imm(im_b),
        .idex_alu_op(op_b), .idex_alusrc(as_b), .idex_regwrite(rw_b),
        .idex_memread(mr_b), .idex_memwrite(mw_b), .idex_memtoreg(mt_b),
        .bubble_count(cnt_b)
    );

    // Field layout of a 70-bit ID/EX word:
    // valid[69] rs[68:65] rt[64:61] rd[60:57] rs_data[56:41]
    // rt_data[40:25] imm[24:9] alu_op[8:5] alusrc[4] regwrite[3]
    // memread[2] memwrite[1] memtoreg[0]
    logic [69:0] obs_a, obs_b, id_vec;
    assign obs_a = {v_a, rs_a, rt_a, rd_a, d1_a, d2_a, im_a, op_a,
                    as_a, rw_a, mr_a, mw_a, mt_a};
    assign obs_b = {v_b, rs_b, rt_b, rd_b, d1_b, d2_b, im_b, op_b,
                    as_b, rw_b, mr_b, mw_b, mt_b};
    assign id_vec = {id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
                     id_imm, id_alu_op, id_alusrc, id_regwrite, id_memread,
                     id_memwrite, id_memtoreg};

    // Reference model: EX-stage contents, bubbles still owed, bubble total.
    logic [69:0] m_reg [2];
    int          m_owed [2];
    int          m_cnt [2];
    int          nb [2]   = '{1, 3};
    int          cmax [2] = '{15, 65535};

    task automatic chk(input string tag, input logic [69:0] obs,
                       input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hz(input int i);
        logic [69:0] r;
        r = m_reg[i];
        return id_valid && r[69] && r[2] && (r[60:57] != 4'd0) &&
               ((r[60:57] == id_rs) || (id_uses_rt && r[60:57] == id_rt));
    endfunction

    function automatic bit m_pc(input int i);
        if (!rst_n || mem_hold) return 1'b0;
        if (ex_flush) return 1'b1;
        if (m_owed[i] > 0) return 1'b0;
        return !m_hz(i);
    endfunction

    function automatic void m_edge(input int i);
        if (!rst_n) begin
            m_reg[i] = '0; m_owed[i] = 0; m_cnt[i] = 0;
        end else if (mem_hold) begin
            // frozen
        end else if (ex_flush) begin
            m_reg[i] = '0; m_owed[i] = 0;
        end else if (m_owed[i] > 0 || m_hz(i)) begin
            m_owed[i] = (m_owed[i] > 0) ? m_owed[i] - 1 : nb[i] - 1;
            m_reg[i] = '0;
            if (m_cnt[i] < cmax[i]) m_cnt[i]++;
        end else begin
            m_reg[i] = id_valid ? id_vec : '0;
        end
    endfunction

    task automatic step();
        #1;
        chk("pc_write_a", {69'd0, pcw_a}, {69'd0, m_pc(0)});
        chk("ifid_write_a", {69'd0, ifw_a}, {69'd0, m_pc(0)});
        chk("pc_write_b", {69'd0, pcw_b}, {69'd0, m_pc(1)});
        chk("ifid_write_b", {69'd0, ifw_b}, {69'd0, m_pc(1)});
        @(posedge clk);
        m_edge(0);
        m_edge(1);
        #1;
        chk("idex_a", obs_a, m_reg[0]);
        chk("idex_b", obs_b, m_reg[1]);
        chk("count_a", {66'd0, cnt_a}, 70'(m_cnt[0]));
        chk("count_b", {54'd0, cnt_b}, 70'(m_cnt[1]));
    endtask

    task automatic rand_id();
        id_valid    = 1'($urandom);
        id_rs       = 4'($urandom);
        id_rt       = 4'($urandom);
        id_rd       = 4'($urandom);
        id_uses_rt  = 1'($urandom);
        id_rs_data  = 16'($urandom);
        id_rt_data  = 16'($urandom);
        id_imm      = 16'($urandom);
        id_alu_op   = 4'($urandom);
        id_alusrc   = 1'($urandom);
        id_regwrite = 1'($urandom);
        id_memread  = 1'($urandom);
        id_memwrite = 1'($urandom);
        id_memtoreg = 1'($urandom);
    endtask

    task automatic load(input logic [3:0] rd);
        rand_id();
        id_valid = 1'b1; id_memread = 1'b1; id_rd = rd;
        id_rs = 4'd9; id_rt = 4'd9;
    endtask

    task automatic user(input logic [3:0] rs, input logic [3:0] rt,
                        input logic ur);
        rand_id();
        id_valid = 1'b1; id_memread = 1'b0;
        id_rs = rs; id_rt = rt; id_uses_rt = ur; id_rd = 4'd7;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_reg[i] = '0; m_owed[i] = 0; m_cnt[i] = 0;
        end
        ex_flush = 1'b0;
        mem_hold = 1'b0;
        rst_n = 1'b0;
        rand_id();
        @(negedge clk);

        // Reset with random decode inputs
        step();
        rand_id();
        step();
        chk("reset_idex_a", obs_a, 70'd0);
        chk("reset_cnt_b", {54'd0, cnt_b}, 70'd0);
        rst_n = 1'b1;
        id_valid = 1'b0;
        #1;
        chk("release_pc_a", {69'd0, pcw_a}, 70'd1);
        step();

        // Pass-through
        user(4'd3, 4'd4, 1'b1);
        id_rd = 4'd5; id_rs_data = 16'h1234; id_regwrite = 1'b1;
        step();
        chk("pass_rs", {66'd0, rs_a}, 70'd3);
        chk("pass_rt", {66'd0, rt_a}, 70'd4);
        chk("pass_rd", {66'd0, rd_a}, 70'd5);
        chk("pass_data", {54'd0, d1_a}, 70'h1234);
        chk("pass_rw", {69'd0, rw_b}, 70'd1);

        // Load-use on rs
        load(4'd2);
        step();
        user(4'd2, 4'd8, 1'b1);
        #1;
        chk("lu_pc_a", {69'd0, pcw_a}, 70'd0);
        step();
        chk("lu_valid_a", {69'd0, v_a}, 70'd0);
        chk("lu_cnt_a", {66'd0, cnt_a}, 70'd1);
        step();
        chk("lu_enter_a", {69'd0, v_a}, 70'd1);
        step();
        step();
        chk("lu_cnt_b", {54'd0, cnt_b}, 70'd3);
        chk("lu_enter_b", {69'd0, v_b}, 70'd1);

        // Load to r0 never stalls
        load(4'd0);
        step();
        user(4'd0, 4'd0, 1'b1);
        step();
        chk("r0_cnt_a", {66'd0, cnt_a}, 70'd1);

        // rt match ignored when rt is not read
        load(4'd2);
        step();
        user(4'd8, 4'd2, 1'b0);
        step();
        chk("nort_cnt_b", {54'd0, cnt_b}, 70'd3);

        // Flush beats hazard
        load(4'd2);
        step();
        user(4'd2, 4'd2, 1'b1);
        ex_flush = 1'b1;
        step();
        ex_flush = 1'b0;
        chk("flush_cnt_a", {66'd0, cnt_a}, 70'd1);

        // Hold in the middle of a stall
        load(4'd6);
        step();
        user(4'd6, 4'd1, 1'b1);
        step();
        mem_hold = 1'b1;
        for (int k = 0; k < 4; k++) step();
        mem_hold = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("hold_cnt_b", {54'd0, cnt_b}, 70'd6);

        // Random traffic over a small register set
        for (int k = 0; k < 400; k++) begin
            rand_id();
            id_rs = 4'($urandom_range(0, 3));
            id_rt = 4'($urandom_range(0, 3));
            id_rd = 4'($urandom_range(0, 3));
            id_valid = ($urandom_range(0, 9) != 0);
            ex_flush = ($urandom_range(0, 9) == 0);
            mem_hold = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end
        rst_n = 1'b1;
        ex_flush = 1'b0;
        mem_hold = 1'b0;

        // Saturation: a self-dependent load stalls every other cycle
        load(4'd1);
        id_rs = 4'd1;
        for (int k = 0; k < 40; k++) step();
        chk("sat_cnt_a", {66'd0, cnt_a}, 70'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
